// File: rtl/femto_uart_pkg.sv
// rtl/femto_uart_pkg.sv - shared UART state encoding and default bit timing
package femto_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int CLKS_PER_BIT_DEFAULT = 217;

endpackage

// File: rtl/femto_sync2.sv
// rtl/femto_sync2.sv - two-flop synchronizer for a single asynchronous bit
module femto_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/femto_uart_rx.sv
// rtl/femto_uart_rx.sv - 8N1 UART receiver with a one-byte holding register
module femto_uart_rx
    import femto_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxd_s;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             armed_q, armed_d;
    logic             handshake;

    femto_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (rxd),
        .q      (rxd_s)
    );

    assign handshake = valid_q & rx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        armed_d = armed_q;

        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // armed only drops after a frame error or reset, so a held break cannot retrigger
                if (rxd_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxd_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxd_s) begin
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            armed_q <= armed_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/femto_uart_rx.md
FEMTO_UART_RX -- requirements
Module: femto_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per serial bit (25 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rxd  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 SHALL have port rx_data  output  8  received byte, held in the holding register.
REQ-006 SHALL have port rx_valid  output  1  high while the holding register contains an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts the byte in any cycle where rx_valid and rx_ready are both high.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 SHALL have port overrun  output  1  sticky flag: a completed byte was dropped because the holding register was full.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer; both flops reset to 1; the FSM uses only the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA and STOP, plus a bit-time counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-012 IDLE: when synchronized rxd is 0, SHALL go to START and clear the counter.
REQ-013 START: SHALL sample at counter = CLKS_PER_BIT/2-1 (integer division); if 0, go to DATA with the counter cleared; if 1, treat as a glitch and return to IDLE with no output activity.
REQ-014 DATA: SHALL sample when the counter reaches CLKS_PER_BIT-1, shift the sample into bit[index] (LSB first), and clear the counter; after index 7, go to STOP.
REQ-015 STOP: SHALL sample when the counter reaches CLKS_PER_BIT-1, then return to IDLE in the next cycle.
REQ-016 Stop sampled 1 with rx_valid low, or with rx_valid and rx_ready both high in the same cycle: SHALL load rx_data and set rx_valid in the next cycle; overrun unchanged.
REQ-017 Stop sampled 1 with rx_valid high and rx_ready low: SHALL keep the old rx_data, discard the new byte, and set overrun.
REQ-018 Stop sampled 0: SHALL discard the byte, pulse frame_err for exactly one cycle, and leave rx_data, rx_valid and overrun unchanged; the FSM then re-arms only after rxd is seen high in IDLE (a break does not retrigger).
REQ-019 Handshake with no new byte completing: SHALL clear rx_valid in the next cycle.
REQ-020 Any handshake SHALL clear overrun in the next cycle.
REQ-021 rx_data SHALL remain stable while rx_valid is high, except on a simultaneous handshake-and-load.
REQ-022 Latency: rx_valid SHALL rise 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the start-bit falling edge at rxd.
REQ-023 rx_ready SHALL be ignored while rx_valid is low.

Reset
REQ-024 While resetn is low: state=IDLE, counter=0, index=0, synchronizer=11, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no partial byte delivered; after release, reception restarts only on a fresh falling edge.

Structure
REQ-026 Shared package femto_uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP) and the default constant CLKS_PER_BIT_DEFAULT=217, for reuse by a future TX block.
REQ-027 The synchronizer SHALL be a single sub-module, femto_sync2, with 1-bit data and a reset value parameter; everything else stays in femto_uart_rx.

Verification
REQ-028 Send 0x34 at 8680 ns/bit with rx_ready=1 -> one rx_valid cycle with rx_data=0x34, within the REQ-022 window; frame_err=0, overrun=0.
REQ-029 Send 0x34, 0x2A, 0x34, 0x39, 0x2F, 0x30 back-to-back, consuming each byte 10 cycles after rx_valid rises -> bytes delivered in order, all exact, no flags.
REQ-030 Send 0x2A with rx_ready=0, then 0x39 -> rx_data stays 0x2A and overrun=1; a handshake then clears both rx_valid and overrun.
REQ-031 Send 0x55 with the stop bit forced to 0 (break held 20 bit times) -> single frame_err pulse, rx_valid stays 0, no retrigger until rxd returns high; a following 0xA5 is received correctly.
REQ-032 Drive a 50-cycle low glitch on idle rxd -> no rx_valid and no frame_err; the FSM is back in IDLE within CLKS_PER_BIT/2+3 cycles.
REQ-033 Assert resetn low during bit 4 of 0xF0, release, then send 0x0F -> only 0x0F is delivered; all outputs read reset values during reset.
